imem_loader: RTL and testbench

Boot-time program loader that sits between an external byte stream (host link or bench driver) and the CPU's instruction memory write port. It receives a length-prefixed, checksummed stream of 16-bit instructions, writes them into instruction memory from address 0, and holds the CPU in reset until the image is verified. It is the writer counterpart of the memory-observation path: it fills memory before execution, where the bench reads it back after halt.

---
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed, XOR-checksummed
// byte stream, writes 16-bit words from address 0 and releases the CPU once verified.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int RELEASE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge when in_valid && in_ready;
  // in_ready is registered, and in_valid low stalls the FSM with no state change.

  typedef enum logic [2:0] {
    S_LEN_LO  = 3'd0,
    S_LEN_HI  = 3'd1,
    S_DATA_LO = 3'd2,
    S_DATA_HI = 3'd3,
    S_CHECK   = 3'd4,
    S_HOLD    = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  localparam int          CNT_W = (RELEASE_CYC < 2) ? 1 : $clog2(RELEASE_CYC + 1);
  localparam logic [16:0] CAP   = 17'(2 ** ADDR_W);

  state_t              state_q;
  logic                in_ready_q;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [15:0]         imem_wdata_q;
  logic                cpu_rst_q;
  logic                done_q;
  logic                err_q;
  logic [15:0]         len_q;
  logic [7:0]          lo_q;
  logic [7:0]          chk_q;
  logic [ADDR_W:0]     idx_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                xfer;
  logic [15:0]         len_full;
  logic [ADDR_W:0]     idx_nxt;
  logic                idx_last;

  assign xfer     = in_valid && in_ready_q;
  assign len_full = {in_data, len_q[7:0]};
  assign idx_nxt  = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  // Index is one bit wider than the address so a full 2^ADDR_W image ends without wrapping.
  assign idx_last = (16'(idx_nxt) == len_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_LEN_LO;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      len_q        <= '0;
      lo_q         <= '0;
      chk_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_LEN_LO: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            len_q[7:0] <= in_data;
            chk_q      <= chk_q ^ in_data;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q[15:8] <= in_data;
            chk_q       <= chk_q ^ in_data;
            if (len_full == 16'd0) begin
              state_q <= S_CHECK;
            end else if ({1'b0, len_full} > CAP) begin
              state_q    <= S_ERROR;
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= S_DATA_LO;
              idx_q   <= '0;
            end
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            lo_q    <= in_data;
            chk_q   <= chk_q ^ in_data;
            state_q <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            imem_wdata_q <= {in_data, lo_q};
            imem_addr_q  <= idx_q[ADDR_W-1:0];
            imem_we_q    <= 1'b1;
            chk_q        <= chk_q ^ in_data;
            idx_q        <= idx_nxt;
            state_q      <= idx_last ? S_CHECK : S_DATA_LO;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == chk_q) begin
              state_q <= S_HOLD;
              cnt_q   <= '0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_W'(RELEASE_CYC)) begin
            state_q   <= S_DONE;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE, S_ERROR: begin
          if (reload) begin
            state_q    <= S_LEN_LO;
            in_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            chk_q      <= '0;
          end
        end
        default: state_q <= S_LEN_LO;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized streams, a write scoreboard fed by the driver
// and drained by a monitor, plus release/error timing checks.
module tb_imem_loader;

  localparam int ADDR_W      = 8;
  localparam int RELEASE_CYC = 4;
  localparam int CAP         = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W), .RELEASE_CYC(RELEASE_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W+15:0] exp_q[$];
  logic [7:0]         run_x;
  bit                 stall_en;
  logic [15:0]        words[0:CAP-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (imem_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        logic [ADDR_W+15:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h, required addr %0h data %0h",
                   imem_addr, imem_wdata, e[ADDR_W+15:16], e[15:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    if (stall_en) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    run_x    = run_x ^ b;
    while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake_timeout: in_ready stayed %0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic start_stream();
    run_x = 8'h00;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input int addr, input logic [15:0] w);
    exp_q.push_back({ADDR_W'(addr), w});
    send_byte(w[7:0]);
    send_byte(w[15:8]);
  endtask

  task automatic send_chk(input logic [7:0] flip);
    logic [7:0] c;
    c = run_x ^ flip;
    send_byte(c);
  endtask

  // Called just after the CHK transfer edge of a good image.
  task automatic expect_done(input string tag);
    check({tag, "_hold_done"}, done, 1'b0);
    check({tag, "_hold_cpu_rst"}, cpu_rst, 1'b1);
    check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    for (int k = 1; k <= RELEASE_CYC + 1; k++) begin
      @(posedge clk); #1;
      check({tag, "_done_timing"}, done, (k == RELEASE_CYC + 1));
      check({tag, "_cpu_rst_timing"}, cpu_rst, (k != RELEASE_CYC + 1));
    end
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_in_ready_done"}, in_ready, 1'b0);
    check({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_err"}, err, 1'b1);
    check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    @(posedge clk); #1;
    check({tag, "_writes_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_imem_we"}, imem_we, 1'b0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  // Reference outcome: writes for N <= capacity, then done iff checksum matches.
  task automatic run_image(input string tag, input int n, input logic [7:0] flip);
    start_stream();
    send_len(16'(n));
    if (n > CAP) begin
      expect_err(tag);
      return;
    end
    for (int i = 0; i < n; i++) send_word(i, words[i]);
    send_chk(flip);
    if (flip == 8'h00) expect_done(tag);
    else expect_err(tag);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    stall_en = 1'b0;
    run_x    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1'b1);

    // Normal load and bad checksum on the fixed image.
    words[0] = 16'h0123; words[1] = 16'h4567; words[2] = 16'h7000;
    run_image("normal", 3, 8'h00);
    do_reload("reload_done");
    run_image("bad_chk", 3, 8'h01);
    do_reload("reload_err");

    // Same image with random in_valid stalls.
    stall_en = 1'b1;
    run_image("stall", 3, 8'h00);
    stall_en = 1'b0;
    do_reload("reload_stall");

    // Zero length.
    run_image("zero_len", 0, 8'h00);
    do_reload("reload_zero");

    // Oversize rejected after LEN_HI, then a full-capacity image.
    run_image("oversize", CAP + 1, 8'h00);
    do_reload("reload_over");
    for (int i = 0; i < CAP; i++) words[i] = 16'($urandom);
    run_image("full_cap", CAP, 8'h00);
    do_reload("reload_full");

    // Random images with random stalls and occasional corrupted checksums.
    for (int t = 0; t < 6; t++) begin
      int n;
      logic [7:0] flip;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      stall_en = ($urandom_range(0, 1) == 1);
      run_image("random", n, flip);
      stall_en = 1'b0;
      do_reload("reload_random");
    end

    // Reload pulse while waiting in DATA_LO must be ignored.
    start_stream();
    send_len(16'd2);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("ignored_reload_cpu_rst", cpu_rst, 1'b1);
    check("ignored_reload_in_ready", in_ready, 1'b1);
    send_word(0, 16'hbeef);
    send_word(1, 16'h1234);
    send_chk(8'h00);
    expect_done("ignored_reload");
    do_reload("reload_ign");

    // Reset mid-load after the second word, then a fresh single-word image.
    start_stream();
    send_len(16'd4);
    send_word(0, 16'h1111);
    send_word(1, 16'h2222);
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid_reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_in_ready", in_ready, 1'b1);
    check("mid_reset_drained", exp_q.size(), 0);
    words[0] = 16'h6000;
    run_image("after_reset", 1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
